// File: rtl/mem_arb_pkg.sv
// Shared encodings for the CPU/DMA memory arbiter: FSM states, read-owner tags
// and the default DMA burst limit.
package mem_arb_pkg;

    localparam int unsigned DMA_MAX_BURST_DEF = 4;
    localparam int unsigned BURST_W           = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CPU  = 2'd1;
    localparam logic [1:0] ST_DMA  = 2'd2;

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_CPU  = 2'd1;
    localparam logic [1:0] TAG_DMA  = 2'd2;

    // Owner of the read data that returns one cycle after an access in this state.
    function automatic logic [1:0] read_tag(input logic [1:0] state, input logic we);
        logic [1:0] tag;
        tag = TAG_NONE;
        if (!we) begin
            if (state == ST_CPU) tag = TAG_CPU;
            else if (state == ST_DMA) tag = TAG_DMA;
        end
        return tag;
    endfunction

endpackage

// File: rtl/arb_burst_counter.sv
// Saturating count of consecutive DMA grants; cleared whenever the bus goes
// to the CPU or idles.
module arb_burst_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_COUNT = DMA_MAX_BURST_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               clr,
    output logic [BURST_W-1:0] cnt
);

    localparam logic [BURST_W-1:0] MAX_CNT = BURST_W'(MAX_COUNT);

    logic [BURST_W-1:0] cnt_q;
    logic [BURST_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_CNT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, DMA) single-port memory arbiter with 1-cycle grant
// latency, DMA priority bounded by DMA_MAX_BURST, and tagged read return.
//
// state    | meaning
// ST_IDLE  | no owner, memory write strobe low, address/data held
// ST_CPU   | CPU access is on the memory bus this cycle
// ST_DMA   | DMA access is on the memory bus this cycle
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DMA_MAX_BURST = DMA_MAX_BURST_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wr_data,
    output logic        cpu_gnt,
    output logic        cpu_rd_valid,
    output logic [7:0]  cpu_rd_data,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wr_data,
    output logic        dma_gnt,
    output logic        dma_rd_valid,
    output logic [7:0]  dma_rd_data,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wr_data,
    input  logic [7:0]  mem_rd_data
);

    localparam logic [BURST_W-1:0] MAX_CNT = BURST_W'(DMA_MAX_BURST);

    logic [1:0]         state_q, state_d;
    logic [15:0]        mem_addr_q, mem_addr_d;
    logic               mem_we_q, mem_we_d;
    logic [7:0]         mem_wr_data_q, mem_wr_data_d;
    logic [1:0]         rd_tag_q, rd_tag_d;
    logic [BURST_W-1:0] burst_cnt;
    logic               burst_inc;

    always_comb begin
        state_d = ST_IDLE;
        if (cpu_req && dma_req) begin
            state_d = (burst_cnt == MAX_CNT) ? ST_CPU : ST_DMA;
        end else if (dma_req) begin
            state_d = ST_DMA;
        end else if (cpu_req) begin
            state_d = ST_CPU;
        end
    end

    assign burst_inc = (state_d == ST_DMA);

    arb_burst_counter #(
        .MAX_COUNT (DMA_MAX_BURST)
    ) u_burst_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (burst_inc),
        .clr   (!burst_inc),
        .cnt   (burst_cnt)
    );

    always_comb begin
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        mem_we_d      = 1'b0;
        if (state_d == ST_CPU) begin
            mem_addr_d    = cpu_addr;
            mem_wr_data_d = cpu_wr_data;
            mem_we_d      = cpu_we;
        end else if (state_d == ST_DMA) begin
            mem_addr_d    = dma_addr;
            mem_wr_data_d = dma_wr_data;
            mem_we_d      = dma_we;
        end
    end

    // Tag follows the access currently on the bus, so a read issued just before
    // an owner switch still returns to its original requester.
    assign rd_tag_d = read_tag(state_q, mem_we_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mem_addr_q    <= 16'h0000;
            mem_we_q      <= 1'b0;
            mem_wr_data_q <= 8'h00;
            rd_tag_q      <= TAG_NONE;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            mem_we_q      <= mem_we_d;
            mem_wr_data_q <= mem_wr_data_d;
            rd_tag_q      <= rd_tag_d;
        end
    end

    // Outputs are forced to idle values in any cycle reset is high, which also
    // suppresses an in-flight read return or pending write strobe immediately.
    assign cpu_gnt      = !reset && (state_q == ST_CPU);
    assign dma_gnt      = !reset && (state_q == ST_DMA);
    assign mem_we       = !reset && mem_we_q;
    assign mem_addr     = reset ? 16'h0000 : mem_addr_q;
    assign mem_wr_data  = reset ? 8'h00 : mem_wr_data_q;
    assign cpu_rd_valid = !reset && (rd_tag_q == TAG_CPU);
    assign dma_rd_valid = !reset && (rd_tag_q == TAG_DMA);
    assign cpu_rd_data  = mem_rd_data;
    assign dma_rd_data  = mem_rd_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants are queued as stimulus is
// driven and matched against the bus, read returns checked one cycle later.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic [7:0]  cpu_wr_data = 8'h0;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] dma_addr = 16'h0;
    logic [7:0]  dma_wr_data = 8'h0;
    logic        cpu_gnt, cpu_rd_valid, dma_gnt, dma_rd_valid, mem_we;
    logic [7:0]  cpu_rd_data, dma_rd_data, mem_wr_data;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rd_data = 8'h0;

    typedef struct packed {
        logic        dma;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t gnt_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic        rd_pend = 1'b0;
    logic        rd_dma = 1'b0;
    logic [15:0] rd_addr = 16'h0;

    mem_arbiter #(.DMA_MAX_BURST(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_gnt      (cpu_gnt),
        .cpu_rd_valid (cpu_rd_valid),
        .cpu_rd_data  (cpu_rd_data),
        .dma_req      (dma_req),
        .dma_we       (dma_we),
        .dma_addr     (dma_addr),
        .dma_wr_data  (dma_wr_data),
        .dma_gnt      (dma_gnt),
        .dma_rd_valid (dma_rd_valid),
        .dma_rd_data  (dma_rd_data),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_data  (mem_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h03;
    endfunction

    always @(posedge clk) mem_rd_data <= mem_f(mem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic dma, input logic we, input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        e.dma = dma; e.we = we; e.addr = a; e.data = d;
        gnt_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
            chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            chk("rst_cpu_rd_valid", 32'(cpu_rd_valid), 32'd0);
            chk("rst_dma_rd_valid", 32'(dma_rd_valid), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_mem_wr_data", 32'(mem_wr_data), 32'd0);
            rd_pend = 1'b0;
        end else begin
            chk("no_double_gnt", 32'(cpu_gnt & dma_gnt), 32'd0);
            chk("cpu_rd_valid", 32'(cpu_rd_valid), 32'(rd_pend && !rd_dma));
            chk("dma_rd_valid", 32'(dma_rd_valid), 32'(rd_pend && rd_dma));
            if (rd_pend)
                chk("rd_data", 32'(rd_dma ? dma_rd_data : cpu_rd_data), 32'(mem_f(rd_addr)));
            chk("we_without_gnt", 32'(mem_we & ~(cpu_gnt | dma_gnt)), 32'd0);
            rd_pend = 1'b0;
            if (cpu_gnt || dma_gnt) begin
                if (gnt_q.size() == 0) begin
                    chk("gnt_unexpected", 32'({cpu_gnt, dma_gnt}), 32'd0);
                end else begin
                    e = gnt_q.pop_front();
                    chk("gnt_owner", 32'({cpu_gnt, dma_gnt}), 32'({~e.dma, e.dma}));
                    chk("gnt_addr", 32'(mem_addr), 32'(e.addr));
                    chk("gnt_we", 32'(mem_we), 32'(e.we));
                    if (e.we) chk("gnt_wr_data", 32'(mem_wr_data), 32'(e.data));
                    rd_pend = !e.we;
                    rd_dma  = e.dma;
                    rd_addr = e.addr;
                end
            end
        end
    end

    initial begin
        logic [9:0] pat;
        pat = 10'b01111_01111;  // bit k = 1: DMA granted for the request of cycle k

        repeat (3) tick();
        reset = 1'b0;
        tick();

        // single CPU read at the top of memory
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFFFC;
        push(1'b0, 1'b0, 16'hFFFC, 8'h00);
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("cpu_gnt_lat1", 32'(cpu_gnt), 32'd1);
        chk("cpu_mem_addr", 32'(mem_addr), 32'hFFFC);
        tick();
        @(negedge clk);
        chk("cpu_rd_valid_lat2", 32'(cpu_rd_valid), 32'd1);
        chk("cpu_rd_data_ffff", 32'(cpu_rd_data), 32'h00);
        chk("dma_rd_valid_off", 32'(dma_rd_valid), 32'd0);
        tick();

        // contention: both held for ten cycles
        for (int k = 0; k < 10; k++) begin
            cpu_req = 1'b1; dma_req = 1'b1; cpu_we = 1'b0; dma_we = 1'b0;
            cpu_addr = 16'h2000 + 16'(k);
            dma_addr = 16'h1000 + 16'(k);
            if (pat[k]) push(1'b1, 1'b0, 16'h1000 + 16'(k), 8'h00);
            else        push(1'b0, 1'b0, 16'h2000 + 16'(k), 8'h00);
            tick();
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        @(negedge clk); #1;
        chk("contention_drain", 32'(gnt_q.size()), 32'd0);
        tick();

        // DMA write
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0200; dma_wr_data = 8'hA5;
        push(1'b1, 1'b1, 16'h0200, 8'hA5);
        tick();
        dma_req = 1'b0; dma_we = 1'b0;
        @(negedge clk);
        chk("dma_wr_we", 32'(mem_we), 32'd1);
        tick();
        @(negedge clk);
        chk("idle_we_low", 32'(mem_we), 32'd0);
        chk("idle_addr_hold", 32'(mem_addr), 32'h0200);
        chk("idle_data_hold", 32'(mem_wr_data), 32'hA5);
        chk("wr_no_rd_valid", 32'(dma_rd_valid), 32'd0);
        tick();

        // owner switch: DMA read then CPU read back to back
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0010;
        push(1'b1, 1'b0, 16'h0010, 8'h00);
        tick();
        dma_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
        push(1'b0, 1'b0, 16'h0020, 8'h00);
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("sw_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("sw_dma_rd_valid", 32'(dma_rd_valid), 32'd1);
        chk("sw_dma_rd_data", 32'(dma_rd_data), 32'h13);
        tick();
        @(negedge clk);
        chk("sw_cpu_rd_valid", 32'(cpu_rd_valid), 32'd1);
        chk("sw_cpu_rd_data", 32'(cpu_rd_data), 32'h23);
        tick();

        // DMA alone keeps the bus; a CPU request withdrawn before grant is dropped
        for (int k = 0; k < 8; k++) begin
            dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h3000 + 16'(k);
            cpu_req = (k < 2); cpu_addr = 16'h4000;
            push(1'b1, 1'b0, 16'h3000 + 16'(k), 8'h00);
            tick();
        end
        dma_req = 1'b0; cpu_req = 1'b0;
        @(negedge clk); #1;
        chk("dma_only_drain", 32'(gnt_q.size()), 32'd0);
        tick();

        // reset in the cycle after a CPU read grant
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        push(1'b0, 1'b0, 16'h0040, 8'h00);
        tick();
        cpu_req = 1'b0;
        tick();
        reset = 1'b1;
        cpu_req = 1'b1; cpu_addr = 16'h0050;
        @(negedge clk);
        chk("rst_rd_dropped", 32'(cpu_rd_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("rst_next_gnt", 32'(cpu_gnt), 32'd0);
        tick();
        reset = 1'b0;
        push(1'b0, 1'b0, 16'h0050, 8'h00);
        @(negedge clk);
        chk("post_rst_no_early_gnt", 32'(cpu_gnt), 32'd0);
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("post_rst_first_gnt", 32'(cpu_gnt), 32'd1);
        repeat (3) tick();
        chk("final_drain", 32'(gnt_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DMA_MAX_BURST, default 4, meaning the maximum consecutive DMA grants while the CPU is waiting; the legal range is 1..15.
REQ-002 clk  input  1  clock; all logic SHALL be on its rising edge.
REQ-003 reset  input  1  synchronous reset, active-high.
REQ-004 cpu_req  input  1  CPU access request; held until cpu_gnt is sampled high.
REQ-005 cpu_we  input  1  CPU write enable (1=write, 0=read).
REQ-006 cpu_addr  input  16  CPU byte address.
REQ-007 cpu_wr_data  input  8  CPU write data.
REQ-008 cpu_gnt  output  1  the CPU access is on the memory bus this cycle.
REQ-009 cpu_rd_valid  output  1  cpu_rd_data is valid this cycle.
REQ-010 cpu_rd_data  output  8  CPU read data.
REQ-011 dma_req, dma_we, dma_addr[15:0], dma_wr_data[7:0]  input  the DMA requester equivalents of REQ-004..007.
REQ-012 dma_gnt, dma_rd_valid, dma_rd_data[7:0]  output  the DMA equivalents of REQ-008..010.
REQ-013 mem_addr  output  16  memory address, registered.
REQ-014 mem_we  output  1  memory write strobe, registered.
REQ-015 mem_wr_data  output  8  memory write data, registered.
REQ-016 mem_rd_data  input  8  memory read data, valid one cycle after the read address is presented.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE (no owner), CPU (the CPU owns the bus this cycle) and DMA (the DMA owns the bus this cycle); one access SHALL be issued per cycle.
REQ-018 Requests sampled at edge N SHALL, if granted, place addr/we/wr_data on mem_* and raise the matching gnt during cycle N+1, so arbitration latency is 1 cycle.
REQ-019 The next-state rule: no req -> IDLE; dma_req only -> DMA; cpu_req only -> CPU.
REQ-020 When both requests are high, the next state SHALL be DMA unless burst_cnt == DMA_MAX_BURST, in which case it SHALL be CPU.
REQ-021 burst_cnt (4 bits) SHALL increment on each DMA grant, saturate at DMA_MAX_BURST, and clear on any CPU or IDLE cycle.
REQ-022 With only dma_req asserted, DMA SHALL be granted every cycle indefinitely, and burst_cnt SHALL stay saturated.
REQ-023 cpu_gnt and dma_gnt SHALL never be high in the same cycle.
REQ-024 In IDLE, mem_we SHALL be 0 and mem_addr/mem_wr_data SHALL hold their last value.
REQ-025 mem_we SHALL be high for exactly one cycle per granted write.
REQ-026 A read granted in cycle N+1 SHALL return mem_rd_data on the owner's rd_data with rd_valid high in cycle N+2.
REQ-027 rd_valid SHALL be one cycle wide, driven from a registered owner tag.
REQ-028 The non-owner rd_valid SHALL be 0 in every cycle.
REQ-029 rd_data SHALL be mem_rd_data passed through to both requesters; it is qualified only by rd_valid.
REQ-030 Back-to-back grants, including owner switches, SHALL incur no bubble cycle.
REQ-031 Read data for an access issued in the last cycle before an owner switch SHALL still go to the original owner.
REQ-032 A requester that deasserts req without being granted SHALL not be granted.
REQ-033 A requester that keeps req high after its gnt SHALL be treated as issuing a new request.

Reset
REQ-034 While reset is high, the FSM SHALL be IDLE and burst_cnt SHALL be 0.
REQ-035 While reset is high, cpu_gnt, dma_gnt, mem_we, cpu_rd_valid and dma_rd_valid SHALL be 0.
REQ-036 While reset is high, mem_addr SHALL be 16'h0000, mem_wr_data SHALL be 8'h00, and the read-valid tag SHALL be cleared.
REQ-037 Reset asserted mid-operation SHALL drop any in-flight read with no rd_valid pulse, and SHALL abort any pending grant without a mem_we pulse.
REQ-038 The first grant after reset deasserts SHALL occur no earlier than 1 cycle after the first cycle with reset low.

Structure
REQ-039 A shared package mem_arb_pkg SHALL hold the state encoding (IDLE/CPU/DMA), the owner-tag encoding and the default DMA_MAX_BURST constant.
REQ-040 The block SHALL contain one sub-module, arb_burst_counter, implementing the saturating burst counter with clear.

Verification
REQ-041 CPU-only reads: cpu_req with addr 16'hFFFC at edge 0 -> cpu_gnt=1 and mem_addr=FFFC in cycle 1; with mem_rd_data=8'h00 in cycle 2 -> cpu_rd_valid=1, cpu_rd_data=8'h00 in cycle 2, dma_rd_valid=0.
REQ-042 Contention: both req held continuously, DMA_MAX_BURST=4 -> grant pattern D,D,D,D,C,D,D,D,D,C...
REQ-043 Contention check: across the REQ-042 pattern, gnt is never double-asserted.
REQ-044 Write: dma_we=1, addr 16'h0200, data 8'hA5 -> exactly one cycle of mem_we=1 with mem_addr=0200 and mem_wr_data=A5, then dma_rd_valid=0.
REQ-045 Owner switch read routing: DMA read at 16'h0010 followed immediately by CPU read at 16'h0020 -> dma_rd_valid with data(0010) in the cycle before cpu_rd_valid with data(0020), and no bubble.
REQ-046 Reset mid-read: assert reset in the cycle after a CPU read grant -> no cpu_rd_valid pulse; all outputs at reset values the next cycle; the first grant comes 1 cycle after reset deasserts.
